// File: rtl/key_event_decoder.sv
// ============================================================================
// Module   : key_event_decoder
// Purpose  : Turns one debounced key level into single-cycle press, release,
//            click, long-press and (with KEY_EVENT_REPEAT_EN) auto-repeat
//            events, plus a registered "held" level.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module key_event_decoder #(
    parameter bit          ACTIVE_LOW    = 1'b1,
    parameter int unsigned LONG_CYCLES   = 50000000,
    parameter int unsigned REPEAT_CYCLES = 10000000,
    parameter int unsigned CNT_W         = 26
) (
    input  logic clock_50,
    input  logic reset_key,
    input  logic debounced,
    output logic press_pulse,
    output logic release_pulse,
    output logic click_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [1:0] c_WAIT_REL = 2'd0;
    localparam logic [1:0] c_IDLE     = 2'd1;
    localparam logic [1:0] c_HELD     = 2'd2;
    localparam logic [1:0] c_LONG     = 2'd3;

    // HELD counts from 0 on entry, so the long threshold is reached one
    // sample earlier than LONG_CYCLES-1 to land on the LONG_CYCLES-th sample.
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 2);

    generate
        if (LONG_CYCLES < 2 || REPEAT_CYCLES < 1 ||
            CNT_W < $clog2(LONG_CYCLES) || CNT_W < $clog2(REPEAT_CYCLES)) begin : g_bad_params
            $error("key_event_decoder: illegal parameter combination");
        end
    endgenerate

    logic             w_pressed;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             held_q, held_d;

`ifdef KEY_EVENT_REPEAT_EN
    localparam logic [CNT_W-1:0] c_REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic repeat_q, repeat_d;
`endif

    assign w_pressed = debounced ^ ACTIVE_LOW;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;
`ifdef KEY_EVENT_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            c_WAIT_REL: begin
                if (!w_pressed) begin
                    state_d = c_IDLE;
                    cnt_d   = '0;
                end
            end
            c_IDLE: begin
                if (w_pressed) begin
                    state_d = c_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            c_HELD: begin
                // Release is tested first so it beats the long threshold.
                if (!w_pressed) begin
                    state_d   = c_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    click_d   = 1'b1;
                end else if (cnt_q == c_LONG_LAST) begin
                    state_d = c_LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (!w_pressed) begin
                    state_d   = c_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef KEY_EVENT_REPEAT_EN
                    if (cnt_q == c_REP_LAST) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
        endcase
        held_d = (state_d == c_HELD) || (state_d == c_LONG);
    end

    always_ff @(posedge clock_50 or posedge reset_key) begin
        if (reset_key) begin
            state_q   <= c_WAIT_REL;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            long_q    <= long_d;
            held_q    <= held_d;
        end
    end

`ifdef KEY_EVENT_REPEAT_EN
    always_ff @(posedge clock_50 or posedge reset_key) begin
        if (reset_key) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign repeat_pulse = repeat_q;
`else
    assign repeat_pulse = 1'b0;
`endif

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click_pulse   = click_q;
    assign long_pulse    = long_q;
    assign held          = held_q;

endmodule

`default_nettype wire

// File: tb/tb_key_event_decoder.sv
// ============================================================================
// Module   : tb_key_event_decoder
// Purpose  : Scoreboard bench for key_event_decoder (ACTIVE_LOW=0,
//            LONG_CYCLES=8, REPEAT_CYCLES=4); honours KEY_EVENT_REPEAT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_key_event_decoder;

    localparam int c_LONG = 8;
    localparam int c_REP  = 4;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit c_REP_EN = 1'b1;
`else
    localparam bit c_REP_EN = 1'b0;
`endif

    logic clock_50  = 1'b0;
    logic reset_key = 1'b1;
    logic debounced = 1'b1;
    logic w_press, w_release, w_click, w_long, w_repeat, w_held;

    int n_checks = 0;
    int n_errors = 0;

    // Expected outputs, {press, release, click, long, repeat, held}
    logic [5:0] exp_q[$];
    bit m_armed = 1'b0;
    int m_run   = 0;

    key_event_decoder #(
        .ACTIVE_LOW    (1'b0),
        .LONG_CYCLES   (c_LONG),
        .REPEAT_CYCLES (c_REP),
        .CNT_W         (4)
    ) dut (
        .clock_50      (clock_50),
        .reset_key     (reset_key),
        .debounced     (debounced),
        .press_pulse   (w_press),
        .release_pulse (w_release),
        .click_pulse   (w_click),
        .long_pulse    (w_long),
        .repeat_pulse  (w_repeat),
        .held          (w_held)
    );

    always #5 clock_50 = ~clock_50;

    function automatic logic [5:0] outs();
        return {w_press, w_release, w_click, w_long, w_repeat, w_held};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b (press,rel,click,long,rep,held)", tag, obs, exp);
        end
    endtask

    // One clock: drive the level, predict the outputs the spec requires after
    // the edge, then compare once the DUT has registered them.
    task automatic step(input logic lvl, input string tag);
        logic [5:0] e;
        @(negedge clock_50);
        debounced = lvl;
        e = '0;
        if (!m_armed) begin
            if (!lvl) m_armed = 1'b1;
        end else if (lvl) begin
            m_run++;
            e[5] = (m_run == 1);
            e[2] = (m_run == c_LONG);
            e[1] = c_REP_EN && (m_run > c_LONG) && (((m_run - c_LONG) % c_REP) == 0);
            e[0] = 1'b1;
        end else begin
            if (m_run > 0) begin
                e[4] = 1'b1;
                e[3] = (m_run < c_LONG);
            end
            m_run = 0;
        end
        exp_q.push_back(e);
        @(posedge clock_50);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty, got %b", tag, outs());
        end else begin
            check(tag, outs(), exp_q.pop_front());
        end
    endtask

    task automatic run(input logic lvl, input int n, input string tag);
        for (int i = 0; i < n; i++) step(lvl, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_state", outs(), 6'b0);
        @(negedge clock_50);
        reset_key = 1'b0;

        // 1: key already down out of reset is ignored until seen released
        run(1'b1, 10, "t1_held_from_reset");
        run(1'b0, 2,  "t1_released");
        run(1'b1, 3,  "t1_second_press");
        run(1'b0, 2,  "t1_release");

        // 2: short press -> click
        run(1'b1, 3, "t2_short_hold");
        run(1'b0, 2, "t2_click");

        // 3/4: long hold, with repeats when the feature is built in
        run(1'b1, 20, "t34_long_hold");
        run(1'b0, 3,  "t34_release");

        // 5: release sampled on the threshold edge wins
        run(1'b1, 7, "t5_almost_long");
        run(1'b0, 2, "t5_release_wins");

        // exactly LONG_CYCLES pressed samples: long, then release without click
        run(1'b1, 8, "bnd_exact_long");
        run(1'b0, 2, "bnd_exact_release");

        // 6: asynchronous reset mid-hold
        run(1'b1, 4, "t6_hold");
        #2;
        reset_key = 1'b1;
        #1;
        check("t6_async_reset", outs(), 6'b0);
        exp_q.delete();
        m_armed = 1'b0;
        m_run   = 0;
        @(negedge clock_50);
        reset_key = 1'b0;
        run(1'b1, 3, "t6_hold_after_reset");
        run(1'b0, 2, "t6_release_after_reset");
        run(1'b1, 2, "t6_next_press");
        run(1'b0, 2, "t6_next_release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Sits directly downstream of the key debouncer.
- Converts one debounced key level into single-cycle command events for the robot control FSM: press, release, click (short press), long press and, optionally, auto-repeat.
- Also provides a "held" level output.
- One instance per debounced key, in the clock_50 domain.

Parameters:
- ACTIVE_LOW, 1, debounced level that means pressed: 1 means pressed is 0, 0 means pressed is 1.
- LONG_CYCLES, 50000000, consecutive pressed cycles needed for long_pulse (1 s at 50 MHz); must be at least 2.
- REPEAT_CYCLES, 10000000, cycles between repeat_pulse events once in LONG; must be at least 1.
- CNT_W, 26, hold counter width; must be at least clog2(max(LONG_CYCLES, REPEAT_CYCLES)).

Ports:
- clock_50 input 1: system clock; all logic on the rising edge.
- reset_key input 1: asynchronous, active-high reset.
- debounced input 1: debounced key level, already synchronous to clock_50.
- press_pulse output 1: one-cycle pulse on an accepted press.
- release_pulse output 1: one-cycle pulse on release from HELD or LONG.
- click_pulse output 1: one-cycle pulse on release before the long threshold.
- long_pulse output 1: one-cycle pulse when the long threshold is reached.
- repeat_pulse output 1: one-cycle pulse per repeat period in LONG; tied 0 without the macro.
- held output 1: high while in HELD or LONG.

Behaviour:
- pressed = debounced XOR ACTIVE_LOW.
- All outputs are registered.
- States: WAIT_REL, IDLE, HELD, LONG. Counter cnt is CNT_W bits.
- Reset (asynchronous, any time, including mid-hold):
  - state goes to WAIT_REL and cnt to 0;
  - all outputs go to 0 immediately;
  - no release or click pulse is produced for a hold aborted by reset.
- WAIT_REL: guards against a key already down, or the debouncer's reset value reading as pressed. Edge sampling pressed=0 goes to IDLE. No outputs.
- IDLE, on the edge sampling pressed=1 (call it t0):
  - next state HELD, cnt set to 0;
  - press_pulse = 1 for the cycle after t0.
- HELD, pressed=0 sampled:
  - next state IDLE;
  - release_pulse = 1 and click_pulse = 1 for one cycle.
- HELD, pressed=1 sampled:
  - if cnt == LONG_CYCLES-2: next state LONG, cnt set to 0, long_pulse = 1 for one cycle;
  - otherwise cnt increments;
  - net effect: long_pulse follows the edge at t0 + (LONG_CYCLES-1), i.e. the LONG_CYCLES-th consecutive pressed sample.
- Release sampled on the same edge that would reach the threshold: release wins. Result is click plus release, no long.
- LONG, pressed=0 sampled: next state IDLE, release_pulse = 1, no click.
- LONG, pressed=1 sampled: behaviour set by the optional feature.
- held = 1 in every cycle the registered state is HELD or LONG.
- Pulse exclusivity:
  - at most one of press_pulse, long_pulse, repeat_pulse is high in any cycle;
  - click_pulse is only ever high together with release_pulse.
- cnt never wraps. It is cleared on every state entry and stops at its threshold.
- A press that starts while the block is in WAIT_REL is ignored in full: no press, release or click.

Optional Feature:
- Macro KEY_EVENT_REPEAT_EN.
- Defined:
  - in LONG with pressed=1, cnt increments;
  - when cnt == REPEAT_CYCLES-1 at a pressed edge, repeat_pulse = 1 for one cycle and cnt set to 0;
  - so repeat_pulse fires every REPEAT_CYCLES edges after long_pulse, until release.
- Undefined:
  - repeat_pulse is a constant 0;
  - LONG holds cnt at 0 and waits for release;
  - no repeat counter logic is synthesized.

Test Plan (override ACTIVE_LOW=0, LONG_CYCLES=8, REPEAT_CYCLES=4; t0 = first edge sampling pressed=1 in IDLE):
1. Release reset with debounced=1, hold 10 cycles, then 0 for 2 cycles, then 1. Expect no pulses and held=0 through the first hold; press_pulse exactly once only after the second rising level.
2. Press 3 cycles, then release. Expect press_pulse after t0; release_pulse and click_pulse together one cycle after the release edge; long_pulse never asserts; held high 3 cycles.
3. Macro off, hold 20 cycles, release. Expect long_pulse once after edge t0+7; repeat_pulse stays 0; release_pulse with no click_pulse; held drops together with release_pulse.
4. Macro on, hold 20 cycles. Expect long_pulse after t0+7; repeat_pulse after t0+11, t0+15 and t0+19; no repeat after the release edge.
5. Press so that pressed=0 is first sampled at edge t0+7. Expect click_pulse plus release_pulse; long_pulse stays 0.
6. Assert reset_key asynchronously at t0+4 during a hold. Expect all outputs 0 immediately; no release_pulse afterwards even when the key is released; next press accepted normally after the return to IDLE.
